snap_capture_ctrl: RTL and testbench

Sequencer for an ADC snapshot block: arms on a software command, waits for a trigger, streams a fixed-length burst of ADC words into the snapshot BRAM, then raises done. It sits between the software control register, the ADC data stream and the snapshot BRAM, all in the user clock domain. It drives the 32-bit status word that feeds the snapshot's simulink-to-PPC status register.

---
 rtl/snap_pkg.sv | 21 ++
 rtl/snap_capture_ctrl_edge_det.sv | 20 ++
 rtl/snap_capture_ctrl.sv | 116 +++++++++++
 tb/tb_snap_capture_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/snap_pkg.sv
// snap_pkg: shared state encoding, ctrl/status bit positions and helpers for the snapshot sequencer
package snap_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
`ifdef SNAP_TRIG_DELAY_EN
    ST_DELAY   = 3'd2,
`endif
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;
  localparam int ARM_BIT      = 0;
  localparam int TRIG_SRC_BIT = 1;
  localparam int WE_SRC_BIT   = 2;
  localparam int DONE_BIT     = 31;
  localparam int BUSY_BIT     = 30;
  localparam int CNT_W        = 30;
  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction
endpackage

// File: rtl/snap_capture_ctrl_edge_det.sv
// snap_edge_det: registered rising-edge detector, pulse lasts one cycle after the registered bit rises
module snap_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);
  logic d_q, p_q;
  // sample the input, then keep one cycle of history for edge compare
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      d_q <= d_i;
      p_q <= d_q;
    end
  end
  assign rise_o = d_q & ~p_q;
endmodule

// File: rtl/snap_capture_ctrl.sv
// snap_capture_ctrl: arm/trigger/burst sequencer into snapshot BRAM; optional post-trigger delay via SNAP_TRIG_DELAY_EN
module snap_capture_ctrl
  import snap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_in,
`ifdef SNAP_TRIG_DELAY_EN
  input  logic [31:0]       trig_delay_in,
`endif
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig_in,
  input  logic              we_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       status_out
);
  localparam logic [ADDR_W:0] N_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_C = {1'b0, {ADDR_W{1'b1}}};
  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic [31:0]         status_q, status_d;
  logic                arm, acc, trig, go, wr;
  logic                unused_ctrl;
  assign unused_ctrl = ^ctrl_in[31:3];
  snap_edge_det u_arm (
    .clk_i  (user_clk),
    .rst_ni (user_rst_n),
    .d_i    (ctrl_in[ARM_BIT]),
    .rise_o (arm)
  );
  assign acc  = din_valid & (~ctrl_in[WE_SRC_BIT] | we_in);
  assign trig = ctrl_in[TRIG_SRC_BIT] | trig_in;
`ifdef SNAP_TRIG_DELAY_EN
  logic [31:0] dly_q, dly_d;
  assign go = trig & (dly_q == '0);
`else
  assign go = trig;
`endif
  assign wr = acc & ((state_q == ST_CAPTURE) | ((state_q == ST_ARMED) & go));
  // next state, write strobe and counters; an arm edge overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef SNAP_TRIG_DELAY_EN
    dly_d   = dly_q;
`endif
    if (arm) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
`ifdef SNAP_TRIG_DELAY_EN
      dly_d   = trig_delay_in;
`endif
    end else begin
`ifdef SNAP_TRIG_DELAY_EN
      if (state_q == ST_ARMED && trig) state_d = go ? ST_CAPTURE : ST_DELAY;
      if (state_q == ST_DELAY && acc) begin
        dly_d   = dly_q - 32'd1;
        state_d = (dly_q == 32'd1) ? ST_CAPTURE : ST_DELAY;
      end
`else
      if (state_q == ST_ARMED && trig) state_d = ST_CAPTURE;
`endif
      if (wr) begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_W-1:0];
        data_d  = din;
        cnt_d   = (cnt_q == N_C) ? cnt_q : cnt_q + 1'b1;
        state_d = (cnt_q == LAST_C) ? ST_DONE : ST_CAPTURE;
      end
    end
    status_d           = '0;
    status_d[DONE_BIT] = (state_d == ST_DONE);
    status_d[BUSY_BIT] = is_busy(state_d);
    status_d[CNT_W-1:0] = CNT_W'(cnt_d);
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
`ifdef SNAP_TRIG_DELAY_EN
      dly_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      status_q <= status_d;
`ifdef SNAP_TRIG_DELAY_EN
      dly_q    <= dly_d;
`endif
    end
  end
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = data_q;
  assign status_out = status_q;
endmodule

// File: tb/tb_snap_capture_ctrl.sv
// tb_snap_capture_ctrl: scoreboard bench for snap_capture_ctrl with ADDR_W=4 (16-word bursts)
module tb_snap_capture_ctrl;
  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } sb_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ctrl = '0;
  logic [31:0] tdly = '0;
  logic [63:0] din = '0;
  logic        valid = 1'b0;
  logic        trig = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  bram_addr;
  logic [63:0] bram_din;
  logic        bram_we;
  logic [31:0] status_out;
  sb_t         sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc;
  snap_capture_ctrl #(.ADDR_W(4), .DATA_W(64)) dut (
    .user_clk      (clk),
    .user_rst_n    (rst_n),
    .ctrl_in       (ctrl),
`ifdef SNAP_TRIG_DELAY_EN
    .trig_delay_in (tdly),
`endif
    .din           (din),
    .din_valid     (valid),
    .trig_in       (trig),
    .we_in         (we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .status_out    (status_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit push, input logic [3:0] a);
    if (push) sb.push_back('{a, din});
    @(posedge clk);
    #1;
    din = din + 64'd1;
  endtask
  always @(negedge clk) begin
    sb_t e;
    if (bram_we) begin
      if (sb.size() == 0) chk("spurious_we", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(bram_addr), 64'(e.a));
        chk("wr_data", bram_din, e.d);
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(bram_we), 0);
    chk("rst_addr", 64'(bram_addr), 0);
    chk("rst_din", bram_din, 0);
    chk("rst_status", 64'(status_out), 0);
    rst_n = 1'b1;
    valid = 1'b1;
    ctrl = 32'h2;
    step(0, 0);
    step(0, 0);
    // immediate trigger, every valid word written
    for (int k = 0; k < 18; k++) begin
      ctrl = 32'h3;
      step(k >= 2, 4'(k - 2));
      if (k == 0) chk("t1_idle_t1", 64'(status_out), 0);
      if (k == 1) chk("t1_busy_t2", 64'(status_out), 64'h4000_0000);
      if (k == 16) chk("t1_cnt15", 64'(status_out), 64'h4000_000F);
      if (k == 17) chk("t1_done", 64'(status_out), 64'h8000_0010);
    end
    repeat (6) step(0, 0);
    chk("t1_hold_done", 64'(status_out), 64'h8000_0010);
    chk("t1_no_we", 64'(bram_we), 0);
    // external trigger 20 cycles after arm
    ctrl = 32'h0;
    step(0, 0);
    step(0, 0);
    for (int k = 0; k < 36; k++) begin
      ctrl = 32'h1;
      trig = (k == 20);
      step(k >= 20, 4'(k - 20));
      if (k == 10) chk("t2_wait_busy", 64'(status_out), 64'h4000_0000);
      if (k == 19) chk("t2_wait_no_we", 64'(bram_we), 0);
      if (k == 35) chk("t2_done", 64'(status_out), 64'h8000_0010);
    end
    trig = 1'b0;
    // we_in-gated writes
    ctrl = 32'h0;
    step(0, 0);
    step(0, 0);
    n_acc = 0;
    for (int k = 0; k < 36; k++) begin
      ctrl = 32'h7;
      we = k[0];
      step(k >= 2 && we && n_acc < 16, 4'(n_acc));
      if (k >= 2 && we && n_acc < 16) n_acc++;
      if (k == 20) chk("t3_cnt_mid", 64'(status_out), 64'h4000_0009);
      if (k == 35) chk("t3_done", 64'(status_out), 64'h8000_0010);
    end
    we = 1'b0;
    // re-arm after 7 writes
    ctrl = 32'h2;
    step(0, 0);
    step(0, 0);
    for (int k = 0; k < 26; k++) begin
      ctrl = {30'd0, 1'b1, (k < 3 || k >= 8)};
      step((k >= 2 && k <= 8) || k >= 10, (k <= 8) ? 4'(k - 2) : 4'(k - 10));
      if (k == 8) chk("t4_cnt7", 64'(status_out), 64'h4000_0007);
      if (k == 9) chk("t4_rearm", 64'(status_out), 64'h4000_0000);
      if (k == 9) chk("t4_rearm_no_we", 64'(bram_we), 0);
      if (k == 25) chk("t4_done", 64'(status_out), 64'h8000_0010);
    end
    // asynchronous reset mid-burst
    ctrl = 32'h2;
    step(0, 0);
    step(0, 0);
    for (int k = 0; k < 7; k++) begin
      ctrl = 32'h3;
      step(k >= 2, 4'(k - 2));
    end
    ctrl = 32'h2;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", 64'(bram_we), 0);
    chk("t5_rst_addr", 64'(bram_addr), 0);
    chk("t5_rst_din", bram_din, 0);
    chk("t5_rst_status", 64'(status_out), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (20) step(0, 0);
    chk("t5_idle", 64'(status_out), 0);
    // arm held high gives one burst only
    for (int k = 0; k < 41; k++) begin
      ctrl = 32'h3;
      step(k >= 2 && k <= 17, 4'(k - 2));
    end
    chk("t5_single_done", 64'(status_out), 64'h8000_0010);
`ifdef SNAP_TRIG_DELAY_EN
    // post-trigger delay of 3 accepted words, latched at arm
    ctrl = 32'h2;
    step(0, 0);
    step(0, 0);
    tdly = 32'd3;
    for (int k = 0; k < 22; k++) begin
      ctrl = 32'h3;
      if (k == 3) tdly = 32'd7;
      step(k >= 6, 4'(k - 6));
      if (k == 5) chk("t6_delay_busy", 64'(status_out), 64'h4000_0000);
      if (k == 21) chk("t6_done", 64'(status_out), 64'h8000_0010);
    end
    tdly = 32'd0;
`endif
    repeat (3) step(0, 0);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
